uart_tx_fifo: RTL and testbench

//  Parametrised asynchronous serial transmitter with an internal baud divider,

---
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Serial transmitter with a small input FIFO, internal baud divider and a
// configurable frame (data bits, optional parity, one or two stop bits).
// Queued characters go out back-to-back: the pop for the next character
// happens on the final stop-bit edge, so START follows STOP with no gap.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 full, empty;
  logic                 push, pop;

  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic                 baud_done;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  // Full is judged on the current level only, so a same-cycle pop never
  // opens room for a push.
  assign full       = (level == LVL_FULL);
  assign empty      = (level == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign fifo_level = level;
  assign busy       = (state_q != S_IDLE);
  assign baud_done  = (baud_cnt == BAUD_LAST);

  // FIFO storage; data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; pop is only raised when a character is available.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_done && bit_cnt == DATA_LAST)
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (baud_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_done && bit_cnt == STOP_LAST) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Baud and bit counters; both restart whenever a new frame is loaded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (pop || state_q == S_IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (baud_done) begin
      baud_cnt <= '0;
      bit_cnt  <= (state_d != state_q) ? 4'd0 : bit_cnt + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

  // Shift register and parity bit, loaded on pop and shifted per data bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= mem[rd_ptr];
      par_bit <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
    end else if (state_q == S_DATA && baud_done) begin
      shreg   <= shreg >> 1;
    end
  end

  // Registered line driver: one cycle behind the state, every bit CLK_DIV long.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx <= 1'b1;
    end else begin
      case (state_q)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shreg[0];
        S_PAR:   tx <= par_bit;
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7E1 and 7O2 instances at CLK_DIV=4.
module tb_uart_tx_fifo;

  logic clk;
  logic rstn;

  logic       v8, r8, tx8, busy8;
  logic [7:0] d8;
  logic [2:0] lvl8;

  logic       ve, re, txe, busye;
  logic [6:0] de;
  logic [2:0] lvle;

  logic       vo, ro, txo, busyo;
  logic [6:0] dov;
  logic [2:0] lvlo;

  int total;
  int bad;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rstn(rstn), .in_valid(v8), .in_ready(r8), .in_data(d8),
    .tx(tx8), .busy(busy8), .fifo_level(lvl8)
  );

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7e1 (
    .clk(clk), .rstn(rstn), .in_valid(ve), .in_ready(re), .in_data(de),
    .tx(txe), .busy(busye), .fifo_level(lvle)
  );

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
    .clk(clk), .rstn(rstn), .in_valid(vo), .in_ready(ro), .in_data(dov),
    .tx(txo), .busy(busyo), .fifo_level(lvlo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    v8 = 1'b0; d8 = '0;
    ve = 1'b0; de = '0;
    vo = 1'b0; dov = '0;
    repeat (3) tick();
    total++; if (tx8 !== 1'b1)    begin bad++; $display("FAIL reset_tx got=%b want=1", tx8); end
    total++; if (busy8 !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
    total++; if (r8 !== 1'b1)     begin bad++; $display("FAIL reset_ready got=%b want=1", r8); end
    total++; if (lvl8 !== 3'd0)   begin bad++; $display("FAIL reset_level got=%0d want=0", lvl8); end
    total++; if (txe !== 1'b1)    begin bad++; $display("FAIL reset_tx_7e1 got=%b want=1", txe); end
    total++; if (txo !== 1'b1)    begin bad++; $display("FAIL reset_tx_7o2 got=%b want=1", txo); end
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_8n1;
    logic [9:0] fr;
    fr = 10'b1010101010;  // stop, 0x55 LSB first, start
    v8 = 1'b1; d8 = 8'h55;
    tick();  // E0: accepted
    v8 = 1'b0;
    tick();  // E1: popped, still high
    total++; if (tx8 !== 1'b1)   begin bad++; $display("FAIL 8n1_tx_e1 got=%b want=1", tx8); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL 8n1_busy_e1 got=%b want=1", busy8); end
    for (int n = 2; n <= 41; n++) begin
      tick();
      total++;
      if (tx8 !== fr[(n-2)/4]) begin
        bad++; $display("FAIL 8n1_tx n=%0d got=%b want=%b", n, tx8, fr[(n-2)/4]);
      end
      if (n == 40) begin
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL 8n1_busy_stop got=%b want=1", busy8); end
      end
    end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL 8n1_busy_end got=%b want=0", busy8); end
    repeat (3) tick();
  endtask

  task automatic test_parity_even;
    logic [9:0] fr;
    fr = 10'b1000000110;  // stop, parity 0, 0x03 (7 bits), start
    ve = 1'b1; de = 7'h03;
    tick();
    ve = 1'b0;
    tick();
    total++; if (txe !== 1'b1) begin bad++; $display("FAIL 7e1_tx_e1 got=%b want=1", txe); end
    for (int n = 2; n <= 41; n++) begin
      tick();
      total++;
      if (txe !== fr[(n-2)/4]) begin
        bad++; $display("FAIL 7e1_tx n=%0d got=%b want=%b", n, txe, fr[(n-2)/4]);
      end
    end
    total++; if (busye !== 1'b0) begin bad++; $display("FAIL 7e1_busy_end got=%b want=0", busye); end
    repeat (3) tick();
  endtask

  task automatic test_odd_two_stop;
    logic [10:0] f0, f1;
    logic        e;
    f0 = 11'b11100000110;  // 0x03: parity 1, two stops
    f1 = 11'b11100001010;  // 0x05: parity 1, two stops
    vo = 1'b1; dov = 7'h03;
    tick();  // E0
    dov = 7'h05;
    tick();  // E1: push second while first is popped
    vo = 1'b0;
    total++; if (lvlo !== 3'd1) begin bad++; $display("FAIL 7o2_level_e1 got=%0d want=1", lvlo); end
    for (int n = 2; n <= 89; n++) begin
      tick();
      e = ((n-2)/44 == 0) ? f0[((n-2)%44)/4] : f1[((n-2)%44)/4];
      total++;
      if (txo !== e) begin
        bad++; $display("FAIL 7o2_tx n=%0d got=%b want=%b", n, txo, e);
      end
      if (n == 45) begin
        total++; if (busyo !== 1'b1) begin bad++; $display("FAIL 7o2_busy_gap got=%b want=1", busyo); end
      end
    end
    total++; if (busyo !== 1'b0) begin bad++; $display("FAIL 7o2_busy_end got=%b want=0", busyo); end
    repeat (3) tick();
  endtask

  task automatic test_fifo_full;
    logic [7:0] dat [6];
    logic [9:0] fr;
    int         f;
    dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h0F;
    dat[3] = 8'hF0; dat[4] = 8'h81; dat[5] = 8'hFF;
    v8 = 1'b1; d8 = dat[0];
    tick();  // E0
    for (int n = 1; n <= 205; n++) begin
      if (n <= 5) d8 = dat[n];
      else        v8 = 1'b0;
      tick();
      if (n == 4) begin
        total++; if (lvl8 !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", lvl8); end
        total++; if (r8 !== 1'b0)   begin bad++; $display("FAIL full_ready got=%b want=0", r8); end
      end
      if (n == 5) begin
        total++; if (lvl8 !== 3'd4) begin bad++; $display("FAIL full_reject_level got=%0d want=4", lvl8); end
      end
      if (n >= 2 && n <= 201) begin
        f  = (n-2)/40;
        fr = {1'b1, dat[f], 1'b0};
        total++;
        if (tx8 !== fr[((n-2)%40)/4]) begin
          bad++; $display("FAIL full_tx n=%0d got=%b want=%b", n, tx8, fr[((n-2)%40)/4]);
        end
      end
      if (n == 200) begin
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL full_busy_last got=%b want=1", busy8); end
      end
      if (n == 201) begin
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%b want=0", busy8); end
      end
    end
    total++; if (lvl8 !== 3'd0) begin bad++; $display("FAIL full_level_end got=%0d want=0", lvl8); end
    total++; if (tx8 !== 1'b1)  begin bad++; $display("FAIL full_tx_idle got=%b want=1", tx8); end
    repeat (3) tick();
  endtask

  task automatic test_push_pop;
    logic [7:0] dat [4];
    logic [9:0] fr;
    int         f;
    dat[0] = 8'h12; dat[1] = 8'hC3; dat[2] = 8'h7E; dat[3] = 8'h01;
    v8 = 1'b1; d8 = dat[0];
    tick();  // E0
    for (int n = 1; n <= 165; n++) begin
      v8 = 1'b0;
      if (n == 2)  begin v8 = 1'b1; d8 = dat[1]; end
      if (n == 3)  begin v8 = 1'b1; d8 = dat[2]; end
      if (n == 41) begin v8 = 1'b1; d8 = dat[3]; end
      tick();
      if (n == 3 || n == 40 || n == 41) begin
        total++;
        if (lvl8 !== 3'd2) begin bad++; $display("FAIL pp_level n=%0d got=%0d want=2", n, lvl8); end
      end
      if (n >= 2 && n <= 161) begin
        f  = (n-2)/40;
        fr = {1'b1, dat[f], 1'b0};
        total++;
        if (tx8 !== fr[((n-2)%40)/4]) begin
          bad++; $display("FAIL pp_tx n=%0d got=%b want=%b", n, tx8, fr[((n-2)%40)/4]);
        end
      end
      if (n == 161) begin
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL pp_busy_end got=%b want=0", busy8); end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid;
    v8 = 1'b1; d8 = 8'hF0;
    tick();  // E0
    for (int n = 1; n <= 20; n++) begin
      v8 = 1'b0;
      if (n == 2) begin v8 = 1'b1; d8 = 8'h11; end
      if (n == 3) begin v8 = 1'b1; d8 = 8'h22; end
      if (n == 20) rstn = 1'b0;
      tick();
      if (n == 19) begin
        total++; if (tx8 !== 1'b0)  begin bad++; $display("FAIL rm_tx_bit3 got=%b want=0", tx8); end
        total++; if (lvl8 !== 3'd2) begin bad++; $display("FAIL rm_level_pre got=%0d want=2", lvl8); end
      end
    end
    total++; if (tx8 !== 1'b1)   begin bad++; $display("FAIL rm_tx got=%b want=1", tx8); end
    total++; if (lvl8 !== 3'd0)  begin bad++; $display("FAIL rm_level got=%0d want=0", lvl8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy8); end
    total++; if (r8 !== 1'b1)    begin bad++; $display("FAIL rm_ready got=%b want=1", r8); end
    rstn = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      total++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
        bad++; $display("FAIL rm_quiet n=%0d tx=%b busy=%b want tx=1 busy=0", n, tx8, busy8);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_8n1();
    test_parity_even();
    test_odd_two_stop();
    test_fifo_full();
    test_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
